// File: rtl/mem_stage.sv
// RV32I memory stage: issues loads/stores on a req/ack data bus, stalls the
// pipe while the bus is busy, aborts slow transactions and feeds writeback.
module mem_stage #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic [4:0]        rd_addr,
    input  logic              reg_write,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [2:0]        mem_funct3,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [31:0]       dbus_wdata,
    output logic [3:0]        dbus_be,
    input  logic              dbus_ack,
    input  logic [31:0]       dbus_rdata,
    output logic              stall,
    output logic [31:0]       forward_mem,
    output logic [4:0]        rd_addr_out,
    output logic              reg_write_out,
    output logic [31:0]       wb_data,
    output logic              misalign,
    output logic              bus_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int CNT_W = $clog2(MAX_WAIT + 2);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt;

    // Request fields captured at issue; replayed on the bus while BUSY.
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic              reg_write_q;
    logic              load_q;

    logic [1:0]        off;
    logic [3:0]        new_be;
    logic [31:0]       new_wdata;
    logic              aligned;
    logic              is_mem;
    logic              idle;
    logic              busy;
    logic              issue;
    logic              misalign_now;
    logic              timeout;

    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        cur_funct3;
    logic [4:0]        cur_rd;
    logic              cur_reg_write;
    logic              cur_we;
    logic              cur_load;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_val;

    assign off = alu_result[1:0];

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missed branch would otherwise infer a latch.
    always_comb begin
        new_be    = 4'b1111;
        new_wdata = store_data;
        aligned   = (off == 2'b00);
        case (mem_funct3[1:0])
            2'b00: begin
                new_be    = 4'b0001 << off;
                new_wdata = {4{store_data[7:0]}};
                aligned   = 1'b1;
            end
            2'b01: begin
                new_be    = 4'b0011 << off;
                new_wdata = {2{store_data[15:0]}};
                aligned   = ~off[0];
            end
            default: ;
        endcase
    end

    assign is_mem       = mem_read | mem_write;
    assign idle         = (state_q == IDLE);
    assign busy         = (state_q == BUSY);
    assign issue        = idle & is_mem & aligned;
    assign misalign_now = idle & is_mem & ~aligned;
    assign timeout      = busy & ~dbus_ack & (wait_cnt == CNT_W'(MAX_WAIT));

    // In BUSY the captured request is authoritative; in IDLE the live inputs are.
    assign cur_addr      = busy ? addr_q      : alu_result[ADDR_W-1:0];
    assign cur_funct3    = busy ? funct3_q    : mem_funct3;
    assign cur_rd        = busy ? rd_q        : rd_addr;
    assign cur_reg_write = busy ? reg_write_q : reg_write;
    assign cur_we        = busy ? we_q        : mem_write;
    assign cur_load      = busy ? load_q      : mem_read;

    assign dbus_req    = rst_n & (issue | busy);
    assign dbus_we     = cur_we;
    assign dbus_addr   = {cur_addr[ADDR_W-1:2], 2'b00};
    assign dbus_wdata  = busy ? wdata_q : new_wdata;
    assign dbus_be     = busy ? be_q    : new_be;
    // An abort releases the pipe just like an ack does.
    assign stall       = dbus_req & ~dbus_ack & ~timeout;
    assign forward_mem = alu_result;

    always_comb begin
        lane_byte = dbus_rdata[8*cur_addr[1:0] +: 8];
        lane_half = cur_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (cur_funct3)
            3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_val = {24'd0, lane_byte};
            3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_val = {16'd0, lane_half};
            default: load_val = dbus_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue && !dbus_ack) state_d = BUSY;
            BUSY:    if (dbus_ack || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wait_cnt      <= '0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            be_q          <= '0;
            funct3_q      <= '0;
            rd_q          <= '0;
            reg_write_q   <= 1'b0;
            load_q        <= 1'b0;
            rd_addr_out   <= '0;
            reg_write_out <= 1'b0;
            wb_data       <= '0;
            misalign      <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_d == BUSY)
                wait_cnt <= busy ? wait_cnt + CNT_W'(1) : CNT_W'(1);
            else
                wait_cnt <= '0;

            if (issue) begin
                addr_q      <= alu_result[ADDR_W-1:0];
                we_q        <= mem_write;
                wdata_q     <= new_wdata;
                be_q        <= new_be;
                funct3_q    <= mem_funct3;
                rd_q        <= rd_addr;
                reg_write_q <= reg_write;
                load_q      <= mem_read;
            end

            misalign <= misalign_now;
            bus_err  <= timeout;

            if (stall) begin
                reg_write_out <= 1'b0;
            end else if (misalign_now || timeout) begin
                rd_addr_out   <= cur_rd;
                reg_write_out <= 1'b0;
            end else begin
                rd_addr_out   <= cur_rd;
                reg_write_out <= cur_reg_write & ~cur_we;
                wb_data       <= cur_load ? load_val : alu_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads/stores with zero and
// multi-cycle waits, misalignment, bus timeout and reset during a transaction.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_result, store_data, dbus_rdata;
    logic [4:0]  rd_addr;
    logic        reg_write, mem_write, mem_read, dbus_ack;
    logic [2:0]  mem_funct3;
    logic        dbus_req, dbus_we, stall, reg_write_out, misalign, bus_err;
    logic [31:0] dbus_addr, dbus_wdata, forward_mem, wb_data;
    logic [3:0]  dbus_be;
    logic [4:0]  rd_addr_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_result(alu_result), .store_data(store_data), .rd_addr(rd_addr),
        .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
        .mem_funct3(mem_funct3),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .stall(stall), .forward_mem(forward_mem),
        .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out),
        .wb_data(wb_data), .misalign(misalign), .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw, input logic mw, input logic mr, input logic [2:0] f3);
        alu_result = alu;
        store_data = sd;
        rd_addr    = rd;
        reg_write  = rw;
        mem_write  = mw;
        mem_read   = mr;
        mem_funct3 = f3;
    endtask

    task automatic nop();
        instr(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        rst_n = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        nop();
        tick(); tick();
        check("rst_req", dbus_req, 0);
        check("rst_stall", stall, 0);
        check("rst_rwo", reg_write_out, 0);
        check("rst_rdo", rd_addr_out, 0);
        check("rst_wb", wb_data, 0);
        check("rst_misalign", misalign, 0);
        check("rst_buserr", bus_err, 0);

        // Plain ALU op
        rst_n = 1'b1;
        instr(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b010);
        #1;
        check("alu_req", dbus_req, 0);
        check("alu_stall", stall, 0);
        check("alu_fwd", forward_mem, 32'h1234);
        tick();
        check("alu_rdo", rd_addr_out, 5);
        check("alu_rwo", reg_write_out, 1);
        check("alu_wb", wb_data, 32'h1234);

        // LB 0x103 with same-cycle ack, then LBU back-to-back
        instr(32'h103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 3'b000);
        dbus_ack = 1'b1; dbus_rdata = 32'h80FF_FFFF;
        #1;
        check("lb_req", dbus_req, 1);
        check("lb_stall", stall, 0);
        check("lb_addr", dbus_addr, 32'h100);
        check("lb_we", dbus_we, 0);
        check("lb_be", dbus_be, 4'b1000);
        tick();
        check("lb_wb", wb_data, 32'hFFFF_FF80);
        check("lb_rwo", reg_write_out, 1);
        check("lb_rdo", rd_addr_out, 7);
        instr(32'h103, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 3'b100);
        #1;
        check("lbu_stall", stall, 0);
        tick();
        check("lbu_wb", wb_data, 32'h0000_0080);
        check("lbu_rdo", rd_addr_out, 8);

        // Halfword and word loads, zero wait
        instr(32'h102, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 3'b001);
        dbus_rdata = 32'h8001_1234;
        tick();
        check("lh_wb", wb_data, 32'hFFFF_8001);
        instr(32'h102, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 3'b101);
        tick();
        check("lhu_wb", wb_data, 32'h0000_8001);
        instr(32'h100, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 3'b010);
        tick();
        check("lw_wb", wb_data, 32'h8001_1234);

        // SB 0x101, zero wait
        instr(32'h101, 32'h1122_335A, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000);
        #1;
        check("sb_be", dbus_be, 4'b0010);
        check("sb_wdata", dbus_wdata, 32'h5A5A_5A5A);
        check("sb_we", dbus_we, 1);
        tick();
        check("sb_rwo", reg_write_out, 0);

        // SH 0x102, ack after 3 cycles
        dbus_ack = 1'b0;
        instr(32'h102, 32'h0000_ABCD, 5'd4, 1'b0, 1'b1, 1'b0, 3'b001);
        #1;
        check("sh_req", dbus_req, 1);
        check("sh_stall0", stall, 1);
        check("sh_be", dbus_be, 4'b1100);
        check("sh_wdata", dbus_wdata, 32'hABCD_ABCD);
        check("sh_addr", dbus_addr, 32'h100);
        for (int i = 1; i <= 2; i++) begin
            tick();
            check("sh_stall_busy", stall, 1);
            check("sh_addr_busy", dbus_addr, 32'h100);
            check("sh_be_busy", dbus_be, 4'b1100);
            check("sh_rwo_bubble", reg_write_out, 0);
        end
        tick();
        dbus_ack = 1'b1;
        #1;
        check("sh_ack_stall", stall, 0);
        check("sh_ack_wdata", dbus_wdata, 32'hABCD_ABCD);
        tick();
        dbus_ack = 1'b0;
        nop();
        #1;
        check("sh_done_rwo", reg_write_out, 0);
        check("sh_done_req", dbus_req, 0);

        // Misaligned LW
        instr(32'h101, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 3'b010);
        #1;
        check("mis_req", dbus_req, 0);
        check("mis_stall", stall, 0);
        tick();
        check("mis_pulse", misalign, 1);
        check("mis_rwo", reg_write_out, 0);
        nop();
        tick();
        check("mis_pulse_end", misalign, 0);

        // LW never acked: aborts on the 15th BUSY cycle
        instr(32'h200, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 3'b010);
        #1;
        check("to_issue_stall", stall, 1);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("to_stall", stall, 32'(i < 15));
            check("to_req", dbus_req, 1);
            check("to_buserr_early", bus_err, 0);
        end
        tick();
        nop();
        #1;
        check("to_buserr", bus_err, 1);
        check("to_rwo", reg_write_out, 0);
        check("to_req_after", dbus_req, 0);
        tick();
        check("to_buserr_end", bus_err, 0);

        // LW acked exactly on the 15th BUSY cycle: ack wins
        instr(32'h204, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 3'b010);
        dbus_rdata = 32'hCAFE_F00D;
        for (int i = 1; i <= 14; i++) tick();
        tick();
        dbus_ack = 1'b1;
        #1;
        check("ack15_stall", stall, 0);
        tick();
        dbus_ack = 1'b0;
        nop();
        #1;
        check("ack15_buserr", bus_err, 0);
        check("ack15_wb", wb_data, 32'hCAFE_F00D);
        check("ack15_rwo", reg_write_out, 1);
        check("ack15_rdo", rd_addr_out, 11);

        // Reset in the middle of a BUSY transaction
        instr(32'h300, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 3'b010);
        tick();
        check("rb_busy_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        check("rb_req", dbus_req, 0);
        check("rb_stall", stall, 0);
        tick();
        rst_n = 1'b1;
        nop();
        dbus_ack = 1'b1;
        #1;
        check("rb_late_req", dbus_req, 0);
        check("rb_late_stall", stall, 0);
        tick();
        dbus_ack = 1'b0;
        check("rb_rwo", reg_write_out, 0);
        check("rb_wb", wb_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "timeout");
    end

endmodule
